// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon SRAM master between pixel fetch
// (client 0) and result writeback (client 1).
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WR_WAIT    = 2,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  input  logic              dataready,
  input  logic [DATA_W-1:0] readdata,
  output logic              readen,
  output logic              writen,
  output logic [ADDR_W-1:0] inaddr,
  output logic [DATA_W-1:0] wdata
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR,
    DONE
  } state_t;

  localparam int CMAX =
    (RD_TIMEOUT > WR_WAIT) ? RD_TIMEOUT : WR_WAIT;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] RD_LAST =
    CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WR_LAST =
    CNT_W'(WR_WAIT - 1);

  state_t            state;
  state_t            nxt;
  logic [CNT_W-1:0]  cnt;
  logic              we_l;
  logic              gnt_l;
  logic              err_l;
  logic              last_grant;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_l;
  logic              any_req;
  logic              win1;

  assign any_req = req0 | req1;
  // Client 1 wins only if alone, or on a tie when client 0 went last.
  assign win1 = req1 & (~req0 | ~last_grant);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) nxt = ISSUE;
      end
      ISSUE: begin
        nxt = we_l ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: begin
        if (dataready || cnt == RD_LAST) nxt = DONE;
      end
      WAIT_WR: begin
        if (cnt == WR_LAST) nxt = DONE;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gnt_l   <= 1'b0;
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_l <= win1;
      unique case (1'b1)
        win1: begin
          we_l    <= we1;
          addr_l  <= addr1;
          wdata_l <= wdata1;
        end
        default: begin
          we_l    <= we0;
          addr_l  <= addr0;
          wdata_l <= wdata0;
        end
      endcase
    end
  end

  // One counter serves both the write wait and the read timeout.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        ISSUE:   cnt <= '0;
        WAIT_RD: cnt <= cnt + 1'b1;
        WAIT_WR: cnt <= cnt + 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_l   <= 1'b0;
      rdata_l <= '0;
    end else if (state == ISSUE) begin
      err_l <= 1'b0;
    end else if (state == WAIT_RD) begin
      if (dataready) begin
        rdata_l <= readdata;
        err_l   <= 1'b0;
      end else if (cnt == RD_LAST) begin
        err_l <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_grant <= 1'b1;
    end else if (state == DONE) begin
      last_grant <= gnt_l;
    end
  end

  assign readen = (state == ISSUE) & ~we_l;
  assign writen = (state == ISSUE) & we_l;
  assign ack0   = (state == DONE) & ~gnt_l;
  assign ack1   = (state == DONE) & gnt_l;
  assign err    = (state == DONE) & err_l;
  assign busy   = (state != IDLE);
  assign inaddr = addr_l;
  assign wdata  = wdata_l;
  assign rdata  = rdata_l;

endmodule
